lcd_cmd_host: RTL and testbench

Command-issuing host for the LCD controller's command port. It buffers 4-bit commands pushed by a testbench or upstream sequencer in a small FIFO. It presents each command on `cmd`/`cmd_valid` under the controller's `busy` handshake and holds `cmd` stable while the controller executes. It tracks the terminating command (15) through to the controller's `done`. It sits directly in front of the LCD controller, driving its `cmd`, `cmd_valid` and observing its `busy`, `done`.

---
 rtl/lcd_cmd_host.sv | 158 +++++++++++++++
 tb/tb_lcd_cmd_host.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_host.sv
// lcd_cmd_host: FIFO-buffered command issuer for the LCD controller command port.
// Define LCD_HOST_WDOG_EN to build the watchdog that parks the FSM in HALT.
module lcd_cmd_host #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [3:0]             push_cmd,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   drop,
    output logic [3:0]             cmd,
    output logic                   cmd_valid,
    input  logic                   busy,
    input  logic                   done,
    output logic                   finished,
    output logic                   timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FIN, DONE, HALT} state_t;

    state_t        state;
    logic          wait_first;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_nxt;
    logic          push_ok;
    logic          pop;
    logic          wd_fire;

    // full is the registered pre-pop view, so a push at full is refused even on a pop edge
    assign push_ok = push && !full;
    assign pop     = (state == ISSUE) && !busy;

    always_comb begin
        level_nxt = level;
        if (push_ok && !pop)
            level_nxt = level + LW'(1);
        else if (!push_ok && pop)
            level_nxt = level - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_cmd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            drop   <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
            drop  <= push && full;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cmd        <= 4'd0;
            cmd_valid  <= 1'b0;
            finished   <= 1'b0;
            wait_first <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (level != '0) begin
                        state     <= ISSUE;
                        cmd       <= mem[rd_ptr];
                        cmd_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (!busy) begin
                        cmd_valid  <= 1'b0;
                        wait_first <= 1'b1;
                        state      <= (cmd == 4'hF) ? FIN : WAIT;
                    end else if (wd_fire) begin
                        cmd_valid <= 1'b0;
                        state     <= HALT;
                    end
                end
                WAIT: begin
                    // first WAIT cycle ignores busy; controller may not have raised it yet
                    if (!wait_first && !busy) begin
                        if (level != '0) begin
                            state     <= ISSUE;
                            cmd       <= mem[rd_ptr];
                            cmd_valid <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (wd_fire) begin
                        state <= HALT;
                    end else begin
                        wait_first <= 1'b0;
                    end
                end
                FIN: begin
                    if (done) begin
                        state    <= DONE;
                        finished <= 1'b1;
                    end else if (wd_fire) begin
                        state <= HALT;
                    end
                end
                DONE:    state <= DONE;
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LCD_HOST_WDOG_EN
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wd_cnt;
    logic          wd_active;
    logic          wd_clr;

    // wd_clr mirrors every normal exit from ISSUE/WAIT/FIN, so those always beat expiry
    assign wd_active = state inside {ISSUE, WAIT, FIN};
    assign wd_clr    = pop || (state == WAIT && !wait_first && !busy) || (state == FIN && done);
    assign wd_fire   = wd_active && !wd_clr && (wd_cnt == WW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (wd_clr || !wd_active)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + WW'(1);
            if (wd_fire)
                timeout <= 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_cmd_host.sv
// Directed bench for lcd_cmd_host: vector table plus hand sequences for FIFO and reset corners.
module tb_lcd_cmd_host;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic [3:0] push_cmd = 4'd0;
    logic       busy = 1'b0;
    logic       done = 1'b0;
    logic       full, drop, cmd_valid, finished, timeout;
    logic [3:0] level;
    logic [3:0] cmd;

    lcd_cmd_host #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .push(push), .push_cmd(push_cmd),
        .full(full), .level(level), .drop(drop),
        .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .done(done),
        .finished(finished), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       p;
        logic [3:0] pc;
        logic       b;
        logic       d;
        int         e_cmd;
        int         e_cv;
        int         e_lvl;
        int         e_full;
        int         e_drop;
        int         e_fin;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_cmd"}, cmd, 0);
        chk({tag, "_cv"}, cmd_valid, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_drop"}, drop, 0);
        chk({tag, "_fin"}, finished, 0);
        chk({tag, "_tmo"}, timeout, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; push = 1'b0; busy = 1'b0; done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Releases busy and checks the issued order first, first+1, ...
    task automatic drain(input string tag, input int n, input int first);
        int got = 0;
        for (int c = 0; c < 80 && got < n; c++) begin
            @(negedge clk);
            busy = 1'b0;
            if (cmd_valid && !busy) begin
                chk($sformatf("%s_issue%0d", tag, got), cmd, first + got);
                got++;
            end
        end
        chk({tag, "_count"}, got, n);
    endtask

    task automatic add(input logic r, input logic p, input int pc, input logic b, input logic d,
                       input int ec, input int ev, input int el, input int ef,
                       input int ed, input int efin);
        vec_t v;
        v.r = r; v.p = p; v.pc = 4'(pc); v.b = b; v.d = d;
        v.e_cmd = ec; v.e_cv = ev; v.e_lvl = el; v.e_full = ef; v.e_drop = ed; v.e_fin = efin;
        tbl.push_back(v);
    endtask

    initial begin
        int seen;

        // basic issue: 5 then 15 through to done
        //   r  p  pc  b  d   cmd cv lvl full drop fin
        add(1, 1, 5,  1, 0,   0,  0, 1,  0,   0,   0);
        add(1, 1, 15, 1, 0,   5,  1, 2,  0,   0,   0);
        add(1, 0, 0,  1, 0,   5,  1, 2,  0,   0,   0);
        add(1, 0, 0,  0, 0,   5,  0, 1,  0,   0,   0);
        add(1, 0, 0,  1, 0,   5,  0, 1,  0,   0,   0);
        add(1, 0, 0,  1, 0,   5,  0, 1,  0,   0,   0);
        add(1, 0, 0,  0, 0,   15, 1, 1,  0,   0,   0);
        add(1, 0, 0,  0, 0,   15, 0, 0,  0,   0,   0);
        add(1, 0, 0,  0, 0,   15, 0, 0,  0,   0,   0);
        add(1, 0, 0,  0, 1,   15, 0, 0,  0,   0,   1);
        add(1, 1, 3,  0, 0,   15, 0, 1,  0,   0,   1);
        add(1, 0, 0,  0, 0,   15, 0, 1,  0,   0,   1);
        // command hold: 1 then 11, busy high 4 cycles after the first acceptance
        add(0, 0, 0,  0, 0,   0,  0, 0,  0,   0,   0);
        add(1, 1, 1,  0, 0,   0,  0, 1,  0,   0,   0);
        add(1, 1, 11, 1, 0,   1,  1, 2,  0,   0,   0);
        add(1, 0, 0,  0, 0,   1,  0, 1,  0,   0,   0);
        for (int k = 0; k < 4; k++)
            add(1, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0);
        add(1, 0, 0,  0, 0,   11, 1, 1,  0,   0,   0);
        add(1, 0, 0,  0, 0,   11, 0, 0,  0,   0,   0);
        add(1, 0, 0,  1, 0,   11, 0, 0,  0,   0,   0);
        add(1, 0, 0,  0, 0,   11, 0, 0,  0,   0,   0);
        add(1, 0, 0,  0, 0,   11, 0, 0,  0,   0,   0);

        #3 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_cleared("reset");
        rst = 1'b1;
        busy = 1'b1;
        repeat (70) @(negedge clk);
        chk("preload_cv", cmd_valid, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].r; push = tbl[i].p; push_cmd = tbl[i].pc;
            busy = tbl[i].b; done = tbl[i].d;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_cmd", i), cmd, tbl[i].e_cmd);
            chk($sformatf("v%0d_cv", i), cmd_valid, tbl[i].e_cv);
            chk($sformatf("v%0d_level", i), level, tbl[i].e_lvl);
            chk($sformatf("v%0d_full", i), full, tbl[i].e_full);
            chk($sformatf("v%0d_drop", i), drop, tbl[i].e_drop);
            chk($sformatf("v%0d_fin", i), finished, tbl[i].e_fin);
        end

        // overflow: 9 pushes with busy high, then issue order
        do_reset();
        busy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            push = 1'b1; push_cmd = 4'(2 + k);
        end
        @(negedge clk);
        chk("ovf_level8", level, 8);
        chk("ovf_full", full, 1);
        push_cmd = 4'd12;
        @(negedge clk);
        push = 1'b0;
        chk("ovf_drop", drop, 1);
        chk("ovf_level_hold", level, 8);
        @(negedge clk);
        chk("ovf_drop_pulse", drop, 0);
        drain("ovf", 8, 2);

        // push at full on the same edge as an acceptance
        do_reset();
        busy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            push = 1'b1; push_cmd = 4'(2 + k);
        end
        @(negedge clk);
        chk("pf_cv", cmd_valid, 1);
        push_cmd = 4'd13; busy = 1'b0;
        @(negedge clk);
        push = 1'b0;
        chk("pf_drop", drop, 1);
        chk("pf_level7", level, 7);
        chk("pf_full", full, 0);
        @(negedge clk);
        chk("pf_drop_pulse", drop, 0);
        drain("pf", 7, 3);

`ifdef LCD_HOST_WDOG_EN
        // watchdog: 15 accepted, done never arrives
        do_reset();
        @(negedge clk);
        push = 1'b1; push_cmd = 4'd15;
        @(negedge clk);
        push = 1'b0;
        @(negedge clk);
        chk("wd_issue", cmd_valid, 1);
        @(negedge clk);
        chk("wd_fin_cv", cmd_valid, 0);
        repeat (15) @(negedge clk);
        chk("wd_pre", timeout, 0);
        @(negedge clk);
        chk("wd_timeout", timeout, 1);
        push = 1'b1; push_cmd = 4'd7;
        @(negedge clk);
        push = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (cmd_valid) seen++;
        end
        chk("wd_no_issue", seen, 0);
        chk("wd_level", level, 1);
        rst = 1'b0;
        #1;
        chk_cleared("wd_rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
`endif

        // reset while in WAIT with entries still queued
        do_reset();
        @(negedge clk); push = 1'b1; push_cmd = 4'd4;
        @(negedge clk); push_cmd = 4'd6;
        @(negedge clk); push_cmd = 4'd8;
        @(negedge clk); push = 1'b0;
        chk("mid_wait_cv", cmd_valid, 0);
        chk("mid_level", level, 2);
        rst = 1'b0;
        #1;
        chk_cleared("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (cmd_valid) seen++;
        end
        chk("mid_no_issue", seen, 0);
        push = 1'b1; push_cmd = 4'd10;
        @(negedge clk);
        push = 1'b0;
        chk("mid_new_level", level, 1);
        @(negedge clk);
        chk("mid_new_cv", cmd_valid, 1);
        chk("mid_new_cmd", cmd, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
